// File: rtl/led_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_bank_scheduler
// Function : Time-shares an 8-LED bank between 4 pattern requesters. Owners
//            rotate round-robin on a prescaled tick, each keeping the LEDs
//            for a fixed slot, with an optional all-off gap between owners.
// Revision : 1.0 - initial release
// ============================================================================
module led_bank_scheduler #(
  parameter int PRESCALE_BITS = 18,
  parameter int SLOT_TICKS    = 16,
  parameter int GAP_TICKS     = 1
) (
  input  logic        hwclk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] pat,
  output logic [3:0]  grant,
  output logic [1:0]  owner_id,
  output logic        led1,
  output logic        led2,
  output logic        led3,
  output logic        led4,
  output logic        led5,
  output logic        led6,
  output logic        led7,
  output logic        led8
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] c_slot_last = 8'(SLOT_TICKS - 1);
  // With no gap configured the GAP state is a single pass-through cycle.
  localparam logic [7:0] c_gap_last  = (GAP_TICKS > 0) ? 8'(GAP_TICKS - 1) : 8'd0;

  logic [PRESCALE_BITS-1:0] r_pre_cnt;
  state_t                   r_state;
  logic [3:0]               r_grant;
  logic [1:0]               r_owner;
  logic [1:0]               r_ptr;
  logic [7:0]               r_slot_cnt;
  logic [7:0]               r_gap_cnt;
  logic [7:0]               r_leds;

  state_t                   w_state_n;
  logic [3:0]               w_grant_n;
  logic [1:0]               w_owner_n;
  logic [1:0]               w_ptr_n;
  logic [7:0]               w_slot_n;
  logic [7:0]               w_gap_n;
  logic [7:0]               w_leds_n;

  logic                     w_tick;
  logic                     w_arb_en;
  logic                     w_arb_found;
  logic [1:0]               w_arb_winner;
  logic [1:0]               w_scan_idx;
  logic [3:0]               w_owner_hot;
  logic                     w_others_req;
  logic [7:0]               w_owner_pat;
  logic                     w_slot_end;

  assign w_tick       = &r_pre_cnt;
  assign w_owner_hot  = 4'b0001 << r_owner;
  assign w_others_req = (req & ~w_owner_hot) != 4'b0000;
  assign w_owner_pat  = pat[{r_owner, 3'b000} +: 8];
  assign w_slot_end   = w_tick && (r_slot_cnt == c_slot_last);

  // Free-running prescaler; deliberately untouched by FSM transitions.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  // Round-robin scan: walk from ptr+3 down to ptr so the nearest hit wins.
  always_comb begin
    w_arb_found  = 1'b0;
    w_arb_winner = r_ptr;
    w_scan_idx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_scan_idx = r_ptr + 2'(k);
      if (req[w_scan_idx]) begin
        w_arb_found  = 1'b1;
        w_arb_winner = w_scan_idx;
      end
    end
  end

  // Next-state and registered-output logic for IDLE / OWN / GAP.
  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
    w_slot_n  = r_slot_cnt;
    w_gap_n   = r_gap_cnt;
    w_leds_n  = 8'd0;
    w_arb_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_n = 4'b0000;
        w_arb_en  = 1'b1;
      end
      S_OWN: begin
        w_leds_n = w_owner_pat;
        if (w_tick) begin
          w_slot_n = r_slot_cnt + 8'd1;
        end
        // Release beats expiry; expiry only hands over if someone else waits.
        if (!req[r_owner] || (w_slot_end && w_others_req)) begin
          w_state_n = S_GAP;
          w_grant_n = 4'b0000;
          w_leds_n  = 8'd0;
          w_gap_n   = 8'd0;
        end else if (w_slot_end) begin
          w_slot_n = 8'd0;
        end
      end
      S_GAP: begin
        w_grant_n = 4'b0000;
        if (w_tick) begin
          w_gap_n = r_gap_cnt + 8'd1;
        end
        if ((GAP_TICKS == 0) || (w_tick && (r_gap_cnt == c_gap_last))) begin
          w_arb_en  = 1'b1;
          w_state_n = S_IDLE;
          w_gap_n   = 8'd0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_grant_n = 4'b0000;
      end
    endcase
    // A successful arbitration overrides whatever IDLE/GAP chose above.
    if (w_arb_en && w_arb_found) begin
      w_state_n = S_OWN;
      w_grant_n = 4'b0001 << w_arb_winner;
      w_owner_n = w_arb_winner;
      w_slot_n  = 8'd0;
      w_ptr_n   = w_arb_winner + 2'd1;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= 4'b0000;
      r_owner    <= 2'd0;
      r_ptr      <= 2'd0;
      r_slot_cnt <= 8'd0;
      r_gap_cnt  <= 8'd0;
      r_leds     <= 8'd0;
    end else begin
      r_state    <= w_state_n;
      r_grant    <= w_grant_n;
      r_owner    <= w_owner_n;
      r_ptr      <= w_ptr_n;
      r_slot_cnt <= w_slot_n;
      r_gap_cnt  <= w_gap_n;
      r_leds     <= w_leds_n;
    end
  end

  assign grant    = r_grant;
  assign owner_id = r_owner;
  assign led1     = r_leds[0];
  assign led2     = r_leds[1];
  assign led3     = r_leds[2];
  assign led4     = r_leds[3];
  assign led5     = r_leds[4];
  assign led6     = r_leds[5];
  assign led7     = r_leds[6];
  assign led8     = r_leds[7];

endmodule
`default_nettype wire

// File: tb/tb_led_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_bank_scheduler
// Function : Directed self-checking bench for led_bank_scheduler. Two
//            instances: GAP_TICKS=1 (main) and GAP_TICKS=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_bank_scheduler;

  logic        hwclk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] pat;
  logic [3:0]  grant;
  logic [1:0]  owner_id;
  logic        led1, led2, led3, led4, led5, led6, led7, led8;
  logic [3:0]  req0;
  logic [31:0] pat0;
  logic [3:0]  grant0;
  logic [1:0]  owner0;
  logic        m1, m2, m3, m4, m5, m6, m7, m8;

  logic [7:0]  leds;
  logic [7:0]  leds0;
  assign leds  = {led8, led7, led6, led5, led4, led3, led2, led1};
  assign leds0 = {m8, m7, m6, m5, m4, m3, m2, m1};

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] c_pat = 32'h443C_A511;

  led_bank_scheduler #(.PRESCALE_BITS(2), .SLOT_TICKS(3), .GAP_TICKS(1)) dut (
    .hwclk(hwclk), .rst_n(rst_n), .req(req), .pat(pat),
    .grant(grant), .owner_id(owner_id),
    .led1(led1), .led2(led2), .led3(led3), .led4(led4),
    .led5(led5), .led6(led6), .led7(led7), .led8(led8)
  );

  led_bank_scheduler #(.PRESCALE_BITS(2), .SLOT_TICKS(3), .GAP_TICKS(0)) dut_g0 (
    .hwclk(hwclk), .rst_n(rst_n), .req(req0), .pat(pat0),
    .grant(grant0), .owner_id(owner0),
    .led1(m1), .led2(m2), .led3(m3), .led4(m4),
    .led5(m5), .led6(m6), .led7(m7), .led8(m8)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  task automatic step(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  // Reset both DUTs, then release at a negedge; the next posedge is P1.
  task automatic reset_and_release(input logic [3:0] r, input logic [3:0] r0);
    @(negedge hwclk);
    rst_n = 1'b0;
    req   = 4'b0000;
    req0  = 4'b0000;
    step(2);
    req   = r;
    req0  = r0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    bit ok;
    #2;
    checks++;
    if ({grant, owner_id, leds} !== 14'd0) begin
      errors++;
      $display("FAIL reset_initial: got grant=%b owner=%0d leds=%h, want all 0", grant, owner_id, leds);
    end
    reset_and_release(4'b0100, 4'b0000);
    step(3);
    checks++;
    if (grant !== 4'b0100 || leds !== 8'h3C) begin
      errors++;
      $display("FAIL reset_pre_own: got grant=%b leds=%h, want 0100 3c", grant, leds);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, owner_id, leds} !== 14'd0) begin
      errors++;
      $display("FAIL reset_async: got grant=%b owner=%0d leds=%h, want all 0", grant, owner_id, leds);
    end
    req = 4'b0000;
    @(negedge hwclk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge hwclk);
      if ({grant, owner_id, leds} !== 14'd0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_idle: got grant=%b owner=%0d leds=%h, want all 0", grant, owner_id, leds);
    end
  endtask

  task automatic test_single;
    bit ok;
    reset_and_release(4'b0010, 4'b0000);
    step(1);
    checks++;
    if (grant !== 4'b0010 || owner_id !== 2'd1 || leds !== 8'h00) begin
      errors++;
      $display("FAIL single_grant: got grant=%b owner=%0d leds=%h, want 0010 1 00", grant, owner_id, leds);
    end
    step(1);
    checks++;
    if (leds !== 8'hA5) begin
      errors++;
      $display("FAIL single_leds: got leds=%h, want a5", leds);
    end
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge hwclk);
      if (grant !== 4'b0010 || leds !== 8'hA5) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_hold: got grant=%b leds=%h, want 0010 a5 throughout", grant, leds);
    end
    pat[7:0] = 8'hFF;
    pat[15:8] = 8'h5A;
    step(1);
    checks++;
    if (leds !== 8'h5A) begin
      errors++;
      $display("FAIL single_pat_follow: got leds=%h, want 5a", leds);
    end
    pat = c_pat;
  endtask

  task automatic test_round_robin;
    logic [13:0] exp_v;
    int m, o, ph;
    bit multi_ok;
    reset_and_release(4'b1111, 4'b0000);
    multi_ok = 1'b1;
    for (int n = 1; n <= 75; n++) begin
      @(negedge hwclk);
      if (n < 12)
        exp_v = {4'b0001, 2'd0, (n == 1) ? 8'h00 : c_pat[7:0]};
      else if (n < 16)
        exp_v = {4'b0000, 2'd0, 8'h00};
      else begin
        m  = n - 16;
        o  = (1 + m / 16) % 4;
        ph = m % 16;
        if (ph < 12)
          exp_v = {4'(1 << o), 2'(o), (ph == 0) ? 8'h00 : c_pat[o*8 +: 8]};
        else
          exp_v = {4'b0000, 2'(o), 8'h00};
      end
      if ($countones(grant) > 1) multi_ok = 1'b0;
      checks++;
      if ({grant, owner_id, leds} !== exp_v) begin
        errors++;
        $display("FAIL rr_cycle%0d: got grant=%b owner=%0d leds=%h, want grant=%b owner=%0d leds=%h",
                 n, grant, owner_id, leds, exp_v[13:10], exp_v[9:8], exp_v[7:0]);
      end
    end
    checks++;
    if (!multi_ok) begin
      errors++;
      $display("FAIL rr_onehot: grant was multi-hot, want at most one bit");
    end
  endtask

  task automatic test_early_release;
    reset_and_release(4'b0100, 4'b0000);
    step(2);                       // P2
    checks++;
    if (grant !== 4'b0100 || leds !== 8'h3C) begin
      errors++;
      $display("FAIL early_own: got grant=%b leds=%h, want 0100 3c", grant, leds);
    end
    req = 4'b1101;
    step(3);                       // P5, one tick consumed at P4
    req = 4'b1001;
    step(1);                       // P6
    checks++;
    if (grant !== 4'b0000 || leds !== 8'h00 || owner_id !== 2'd2) begin
      errors++;
      $display("FAIL early_release: got grant=%b owner=%0d leds=%h, want 0000 2 00", grant, owner_id, leds);
    end
    step(1);                       // P7
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL early_gap: got grant=%b, want 0000", grant);
    end
    step(1);                       // P8
    checks++;
    if (grant !== 4'b1000 || owner_id !== 2'd3) begin
      errors++;
      $display("FAIL early_next3: got grant=%b owner=%0d, want 1000 3", grant, owner_id);
    end
    step(11);                      // P19
    checks++;
    if (grant !== 4'b1000 || leds !== 8'h44) begin
      errors++;
      $display("FAIL early_own3: got grant=%b leds=%h, want 1000 44", grant, leds);
    end
    step(1);                       // P20
    checks++;
    if (grant !== 4'b0000 || leds !== 8'h00) begin
      errors++;
      $display("FAIL early_gap3: got grant=%b leds=%h, want 0000 00", grant, leds);
    end
    step(4);                       // P24
    checks++;
    if (grant !== 4'b0001 || owner_id !== 2'd0) begin
      errors++;
      $display("FAIL early_next0: got grant=%b owner=%0d, want 0001 0", grant, owner_id);
    end
  endtask

  task automatic test_pointer_skip;
    bit ok;
    reset_and_release(4'b0001, 4'b0000);
    step(1);                       // P1
    req = 4'b1001;
    step(11);                      // P12
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL skip_expire: got grant=%b, want 0000", grant);
    end
    step(4);                       // P16
    checks++;
    if (grant !== 4'b1000 || owner_id !== 2'd3) begin
      errors++;
      $display("FAIL skip_winner3: got grant=%b owner=%0d, want 1000 3", grant, owner_id);
    end
    step(1);                       // P17
    req = 4'b0000;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin   // P18..P21
      @(negedge hwclk);
      if (grant !== 4'b0000 || leds !== 8'h00 || owner_id !== 2'd3) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL skip_to_idle: got grant=%b owner=%0d leds=%h, want 0000 3 00", grant, owner_id, leds);
    end
    req = 4'b0010;
    step(1);                       // P22, not a tick edge: only IDLE grants here
    checks++;
    if (grant !== 4'b0010 || owner_id !== 2'd1) begin
      errors++;
      $display("FAIL skip_idle_arb: got grant=%b owner=%0d, want 0010 1", grant, owner_id);
    end
  endtask

  task automatic test_gap0;
    pat0 = 32'h0000_F00F;
    reset_and_release(4'b0000, 4'b0011);
    step(11);                      // P11
    checks++;
    if (grant0 !== 4'b0001 || leds0 !== 8'h0F) begin
      errors++;
      $display("FAIL gap0_own0: got grant=%b leds=%h, want 0001 0f", grant0, leds0);
    end
    step(1);                       // P12
    checks++;
    if (grant0 !== 4'b0000 || leds0 !== 8'h00) begin
      errors++;
      $display("FAIL gap0_blank: got grant=%b leds=%h, want 0000 00", grant0, leds0);
    end
    step(1);                       // P13
    checks++;
    if (grant0 !== 4'b0010 || owner0 !== 2'd1 || leds0 !== 8'h00) begin
      errors++;
      $display("FAIL gap0_own1: got grant=%b owner=%0d leds=%h, want 0010 1 00", grant0, owner0, leds0);
    end
    step(1);                       // P14
    checks++;
    if (leds0 !== 8'hF0) begin
      errors++;
      $display("FAIL gap0_leds1: got leds=%h, want f0", leds0);
    end
    step(10);                      // P24
    checks++;
    if (grant0 !== 4'b0000) begin
      errors++;
      $display("FAIL gap0_blank2: got grant=%b, want 0000", grant0);
    end
    step(1);                       // P25
    checks++;
    if (grant0 !== 4'b0001) begin
      errors++;
      $display("FAIL gap0_back0: got grant=%b, want 0001", grant0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    req0  = 4'b0000;
    pat   = c_pat;
    pat0  = 32'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_pointer_skip();
    test_gap0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
